display_mem_reader: RTL and testbench
=====================================

# display_mem_reader

Avalon-MM read master that fetches a block of consecutive 32-bit words from the Nios display system's on-chip memory. It delivers them in order on an Avalon-ST source with ready/valid backpressure, feeding the display refresh path. The Nios side writes frame and segment data into on-chip memory through its slave port. This block reads the same memory through the other port of the interconnect, so display refresh does not load the CPU.

## Interface
- ADDR_W, 16, word address width; matches the 16-bit memory address.
- DATA_W, 32, data width.
- READ_LATENCY, 1, fixed slave read latency in cycles, counted from read acceptance to readdata valid. Legal values are 1–4.
- FIFO_DEPTH, 4, output buffer depth in words. Must be a power of 2 and at least READ_LATENCY+2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only when idle.
- base_addr  in  ADDR_W  first word address, captured on an accepted start.
- word_count  in  16  number of words to read, captured on an accepted start.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse when the transfer is complete.
- avm_address  out  ADDR_W  read word address.
- avm_read  out  1  read request.
- avm_chipselect  out  1  equal to avm_read.
- avm_byteenable  out  4  constant 4'hF.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  DATA_W  read data, valid READ_LATENCY cycles after acceptance.
- st_data  out  DATA_W  stream word.
- st_valid  out  1  st_data is valid.
- st_ready  in  1  downstream accepts the word.
- st_last  out  1  marks the final word of the transfer; qualified by st_valid.

## Operation
- FSM states: IDLE, READ, DRAIN, FINISH.
- IDLE:
  - start with word_count≠0: capture base_addr and word_count, then go to READ.
  - start with word_count=0: go to FINISH; no bus read is issued.
- READ:
  - Assert avm_read when credits allow: (in-flight reads + FIFO occupancy) < FIFO_DEPTH.
  - A read is accepted when avm_read & ~avm_waitrequest.
  - On acceptance, increment the address modulo 2^ADDR_W (0xFFFF wraps to 0x0000) and decrement the issue count.
  - While avm_waitrequest is high, avm_address and avm_read are held stable.
  - When the last read is accepted, go to DRAIN.
- Return path:
  - A READ_LATENCY-deep valid-token shift register, loaded on each acceptance, marks cycles where avm_readdata is valid.
  - Valid returned data is written into the FIFO.
  - Because of the credit rule, the FIFO never overflows; overflow is an assertion failure.
- DRAIN: when the word tagged st_last is accepted (st_valid & st_ready & st_last), go to FINISH.
- FINISH: pulse done for one cycle, deassert busy, then return to IDLE.
- st_last is derived from a 16-bit delivered-word counter equal to word_count−1.
- Data order on the stream equals address order. No word is dropped or duplicated.
- start while busy is ignored; the captured values are unchanged.
- Reset mid-operation:
  - FSM, counters, tokens and FIFO are cleared immediately.
  - Read data still in flight from the slave is discarded because its tokens are cleared.
  - No done pulse is generated.
- Reset values: busy=0, done=0, avm_read=0, avm_chipselect=0, avm_address=0, st_valid=0, st_last=0, st_data=0. avm_byteenable is always 4'hF.

## Timing
- Start is accepted at cycle 0; avm_read is high in cycle 1 with avm_address=base_addr.
- First-word latency is READ_LATENCY+2 cycles from start. With READ_LATENCY=1 and no stalls, st_valid first rises in cycle 3.
- Sustained throughput is 1 word/clk with waitrequest low and st_ready high.
- Backpressure: reads stop within one cycle of the credit limit being reached. While credits are available, issue resumes in the cycle after a FIFO pop.
- done pulses in the cycle after the last handshake. busy falls in the same cycle that done is high.
- st_data, st_valid and st_last are registered; st_data is stable while st_valid & ~st_ready.

## Test plan
- Basic read:
  - Stimulus: memory model preloaded with mem[a]=0xA5000000+a, READ_LATENCY=1; start with base=0x0010, count=8, st_ready=1.
  - Required response: 8 words 0xA5000010..0xA5000017, one per clock; st_last on the 8th word; done 1 cycle later; first st_valid in cycle 3.
- Address wrap: base=0xFFFE, count=4 -> addresses FFFE, FFFF, 0000, 0001 in that order; data matches.
- Backpressure and stalls:
  - Stimulus: random st_ready (50%) and random avm_waitrequest (30%); count=100; READ_LATENCY=2 and 4.
  - Required response: all 100 words in order; no FIFO overflow; avm_address stable during waitrequest.
- Zero count and busy start: word_count=0 -> done 1 cycle after start, no avm_read ever. A second start during a 16-word transfer is ignored; exactly 16 words are delivered.
- Reset mid-transfer: assert reset while 2 reads are in flight on a count=32 transfer. Required: all outputs at reset values the same cycle; no st_valid afterwards even when stale readdata arrives. A new start after release gives a correct transfer.

Source files
------------

// File: rtl/display_mem_reader.sv
// Avalon-MM read master: fetches word_count consecutive words from on-chip memory and streams
// them in address order on an Avalon-ST source, with read credits sized to the output FIFO.
module display_mem_reader #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_chipselect,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_last
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 2;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StFinish} state_e;

  state_e                  state_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    read_q;
  logic                    busy_q;
  logic                    done_q;
  logic [15:0]             issue_left_q;
  logic [15:0]             count_q;
  logic [15:0]             deliv_q;
  logic [READ_LATENCY-1:0] tok_q;
  logic [CW-1:0]           inflight_q;
  logic [CW-1:0]           fcnt_q;
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic [DATA_W-1:0]       fifo_q [FIFO_DEPTH];

  logic          accept;
  logic          push;
  logic          pop;
  logic [CW-1:0] inflight_n;
  logic [CW-1:0] fcnt_n;
  logic [15:0]   issue_left_n;
  logic          credit_ok;

  // A new read is allowed only if every outstanding read still has a FIFO slot waiting for it.
  always_comb begin
    accept       = read_q & ~avm_waitrequest;
    push         = tok_q[READ_LATENCY-1];
    pop          = st_valid & st_ready;
    inflight_n   = inflight_q + CW'(accept) - CW'(push);
    fcnt_n       = fcnt_q + CW'(push) - CW'(pop);
    issue_left_n = issue_left_q - 16'(accept);
    credit_ok    = (inflight_n + fcnt_n) < CW'(FIFO_DEPTH);
  end

  assign avm_address    = addr_q;
  assign avm_read       = read_q;
  assign avm_chipselect = read_q;
  assign avm_byteenable = 4'hF;
  assign busy           = busy_q;
  assign done           = done_q;
  assign st_valid       = (fcnt_q != '0);
  assign st_data        = fifo_q[rd_ptr_q];
  assign st_last        = st_valid && (deliv_q == count_q - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      read_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      issue_left_q <= '0;
      count_q      <= '0;
      deliv_q      <= '0;
      tok_q        <= '0;
      inflight_q   <= '0;
      fcnt_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      // Token shift register marks the cycle each accepted read's data returns.
      tok_q[0] <= accept;
      for (int unsigned i = 1; i < READ_LATENCY; i++) tok_q[i] <= tok_q[i-1];
      inflight_q   <= inflight_n;
      fcnt_q       <= fcnt_n;
      issue_left_q <= issue_left_n;
      if (accept) addr_q <= addr_q + ADDR_W'(1);
      if (push) begin
        fifo_q[wr_ptr_q] <= avm_readdata;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        deliv_q  <= deliv_q + 16'd1;
      end
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            count_q <= word_count;
            deliv_q <= '0;
            if (word_count == '0) begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end else begin
              state_q      <= StRead;
              busy_q       <= 1'b1;
              addr_q       <= base_addr;
              issue_left_q <= word_count;
              read_q       <= 1'b1;
            end
          end
        end
        StRead: begin
          // A stalled request stays up; otherwise issue while words remain and credit allows.
          read_q <= (read_q & avm_waitrequest) | ((issue_left_n != '0) & credit_ok);
          if (accept && (issue_left_q == 16'd1)) state_q <= StDrain;
        end
        StDrain: begin
          if (pop && st_last) begin
            state_q <= StFinish;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (fcnt_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_display_mem_reader.sv
// Bench for display_mem_reader: three instances (latency 1/2/4) share stimulus; each has its own
// memory model returning 0xA5000000 + address after the configured read latency.
module tb_display_mem_reader;
  localparam int N = 3;

  typedef struct {
    logic [15:0] base;
    logic [15:0] cnt;
    int unsigned rdy_pct;
    int unsigned wait_pct;
    int          restart_at;
    logic [31:0] first_w;
    logic [31:0] last_w;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, waitreq, st_ready;
  logic [15:0] base, count;
  logic [31:0] sd [N];
  logic        sv [N], sl [N], ar [N], cs [N], bsy [N], dn [N];
  logic [15:0] aa [N];
  logic [3:0]  be [N];

  int          checks, errors;
  int          idx [N], iss [N], ndone [N];
  bit          hold [N];
  logic [15:0] hold_addr [N];
  logic [31:0] first_w [N], last_w [N];
  logic [15:0] exp_base;
  int          exp_cnt;
  bit          rnd;
  int unsigned rdy_pct, wait_pct;
  vec_t        vecs [7];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int Lat = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    localparam int Dep = (g == 2) ? 8 : 4;
    logic [31:0] pipe [Lat];
    logic        pv [Lat];
    logic [31:0] rdata;

    // Memory model is not reset, so reads in flight across a DUT reset still return data.
    always_ff @(posedge clk) begin
      pipe[0] <= 32'hA500_0000 + {16'h0, aa[g]};
      pv[0]   <= ar[g] & ~waitreq;
      for (int i = 1; i < Lat; i++) begin
        pipe[i] <= pipe[i-1];
        pv[i]   <= pv[i-1];
      end
    end
    assign rdata = pv[Lat-1] ? pipe[Lat-1] : 32'hDEAD_0000;

    display_mem_reader #(
      .ADDR_W(16), .DATA_W(32), .READ_LATENCY(Lat), .FIFO_DEPTH(Dep)
    ) u_dut (
      .clk(clk), .reset(rst), .start(start), .base_addr(base), .word_count(count),
      .busy(bsy[g]), .done(dn[g]), .avm_address(aa[g]), .avm_read(ar[g]),
      .avm_chipselect(cs[g]), .avm_byteenable(be[g]), .avm_waitrequest(waitreq),
      .avm_readdata(rdata), .st_data(sd[g]), .st_valid(sv[g]), .st_ready(st_ready),
      .st_last(sl[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic new_tx(input logic [15:0] b, input logic [15:0] c);
    exp_base = b;
    exp_cnt  = int'(c);
    for (int i = 0; i < N; i++) begin
      idx[i] = 0; iss[i] = 0; ndone[i] = 0; hold[i] = 1'b0;
      first_w[i] = '0; last_w[i] = '0;
    end
  endtask

  // Inputs for the coming edge are already applied, so handshakes are judged exactly as the DUT
  // will see them.
  task automatic monitor();
    logic [15:0] a;
    for (int i = 0; i < N; i++) begin
      if (hold[i]) chk("addr_hold", 64'({ar[i], aa[i]}), 64'({1'b1, hold_addr[i]}));
      if (ar[i] && !waitreq) begin
        a = exp_base + 16'(iss[i]);
        chk("rd_addr", 64'(aa[i]), 64'(a));
        iss[i]++;
      end
      if (sv[i] && st_ready) begin
        a = exp_base + 16'(idx[i]);
        chk("st_data", 64'(sd[i]), 64'(32'hA500_0000 + {16'h0, a}));
        chk("st_last", 64'(sl[i]), 64'(idx[i] == exp_cnt - 1));
        if (idx[i] == 0) first_w[i] = sd[i];
        if (sl[i]) last_w[i] = sd[i];
        idx[i]++;
      end
      if (dn[i]) begin
        chk("words_at_done", 64'(idx[i]), 64'(exp_cnt));
        ndone[i]++;
      end
      hold[i]      = ar[i] && waitreq && !rst;
      hold_addr[i] = aa[i];
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rnd) begin
      st_ready = ($urandom_range(99) < rdy_pct);
      waitreq  = ($urandom_range(99) < wait_pct);
    end
    monitor();
  endtask

  task automatic wait_all();
    int t = 0;
    while (!(ndone[0] > 0 && ndone[1] > 0 && ndone[2] > 0) && t < 3000) begin
      step();
      t++;
    end
    chk("done_timeout", 64'(t < 3000), 64'd1);
  endtask

  task automatic run_tx(input vec_t v);
    new_tx(v.base, v.cnt);
    rdy_pct = v.rdy_pct; wait_pct = v.wait_pct; rnd = 1'b1;
    base = v.base; count = v.cnt; start = 1'b1;
    step();
    start = 1'b0;
    if (v.restart_at != 0) begin
      repeat (v.restart_at) step();
      base = 16'h0999; count = 16'd3; start = 1'b1;
      step();
      start = 1'b0;
    end
    wait_all();
    rnd = 1'b0; st_ready = 1'b1; waitreq = 1'b0;
    repeat (3) step();
    for (int i = 0; i < N; i++) begin
      chk("done_count", 64'(ndone[i]), 64'd1);
      chk("word_total", 64'(idx[i]), 64'(v.cnt));
      chk("first_word", 64'(first_w[i]), 64'(v.first_w));
      chk("last_word", 64'(last_w[i]), 64'(v.last_w));
      chk("busy_after", 64'(bsy[i]), 64'd0);
    end
  endtask

  initial begin
    vecs[0] = '{16'h0010, 16'd8,   100, 0,  0, 32'hA500_0010, 32'hA500_0017};
    vecs[1] = '{16'hFFFE, 16'd4,   100, 0,  0, 32'hA500_FFFE, 32'hA500_0001};
    vecs[2] = '{16'h0100, 16'd100, 50,  30, 0, 32'hA500_0100, 32'hA500_0163};
    vecs[3] = '{16'hFFF0, 16'd40,  50,  30, 0, 32'hA500_FFF0, 32'hA500_0017};
    vecs[4] = '{16'h0040, 16'd0,   100, 0,  0, 32'h0,         32'h0};
    vecs[5] = '{16'h0200, 16'd16,  100, 0,  3, 32'hA500_0200, 32'hA500_020F};
    vecs[6] = '{16'h1234, 16'd1,   70,  20, 0, 32'hA500_1234, 32'hA500_1234};
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; base = '0; count = '0; waitreq = 1'b0; st_ready = 1'b1;
    rnd = 1'b0; rdy_pct = 100; wait_pct = 0;
    new_tx(16'h0, 16'h0);
    repeat (5) step();
    for (int i = 0; i < N; i++)
      chk("reset_outs", 64'({bsy[i], dn[i], ar[i], cs[i], aa[i], sv[i], sl[i], sd[i], be[i]}),
          64'h0F);
    rst = 1'b0;
    repeat (2) step();

    // Basic transfer with exact cycle timing on the latency-1 instance.
    new_tx(16'h0010, 16'd8);
    base = 16'h0010; count = 16'd8; start = 1'b1;
    step();
    start = 1'b0; base = 16'hBEEF; count = 16'd5;
    chk("c1_read", 64'({ar[0], cs[0], aa[0], bsy[0]}), 64'({1'b1, 1'b1, 16'h0010, 1'b1}));
    step();
    chk("c2_no_valid", 64'(sv[0]), 64'd0);
    step();
    chk("c3_first", 64'({sv[0], sl[0], sd[0]}), 64'({1'b1, 1'b0, 32'hA500_0010}));
    repeat (7) step();
    chk("c10_last", 64'({sv[0], sl[0], sd[0]}), 64'({1'b1, 1'b1, 32'hA500_0017}));
    step();
    chk("c11_done", 64'({dn[0], bsy[0]}), 64'({1'b1, 1'b0}));
    step();
    chk("c12_idle", 64'({dn[0], sv[0]}), 64'd0);
    wait_all();
    chk("basic_words", 64'(idx[0]), 64'd8);

    // Zero count: done one cycle after start, no read.
    new_tx(16'h0040, 16'd0);
    base = 16'h0040; count = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_done", 64'({dn[0], bsy[0], ar[0]}), 64'({1'b1, 1'b0, 1'b0}));
    step();
    chk("zero_done_pulse", 64'(dn[0]), 64'd0);
    repeat (3) step();
    chk("zero_no_read", 64'(iss[0] + iss[1] + iss[2]), 64'd0);

    for (int v = 0; v < 7; v++) run_tx(vecs[v]);

    // Reset with reads in flight; stale returns must not reach the stream.
    new_tx(16'h0300, 16'd32);
    base = 16'h0300; count = 16'd32; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++)
      chk("midrst_outs", 64'({bsy[i], dn[i], ar[i], cs[i], aa[i], sv[i], sl[i], sd[i], be[i]}),
          64'h0F);
    repeat (2) step();
    rst = 1'b0;
    repeat (8) begin
      step();
      for (int i = 0; i < N; i++) chk("post_rst_quiet", 64'({sv[i], dn[i], bsy[i]}), 64'd0);
    end
    run_tx(vecs[3]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
